// File: rtl/ll_rsv_pkg.sv
// Shared types and helpers for the LL/SC reservation monitor.
package ll_rsv_pkg;

  localparam int unsigned MaxAddrW = 64;
  localparam int unsigned MaxCh    = 8;

  typedef logic [$clog2(MaxCh)-1:0] ch_idx_t;

  typedef enum logic [2:0] {
    ClrNone,
    ClrFlush,
    ClrSc,
    ClrKill,
    ClrTmo
  } clr_cause_t;

  // Addresses are zero-extended to MaxAddrW by the caller; bits below lsb are ignored.
  function automatic logic gran_match(input logic [MaxAddrW-1:0] a,
                                      input logic [MaxAddrW-1:0] b,
                                      input int unsigned lsb);
    return ((a ^ b) >> lsb) == '0;
  endfunction

endpackage

// File: rtl/ll_rsv_entry.sv
// One reservation channel: valid bit, reserved address and prioritised clear logic.
// Optional lifetime counter enabled by defining LL_RSV_TIMEOUT_EN.
module ll_rsv_entry
  import ll_rsv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ll_vld,
  input  logic              sc_vld,
  input  logic              flush,
  input  logic              kill,
  input  logic [ADDR_W-1:0] ll_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] rsv_addr
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              take_ll;
  logic              tmo_hit;
  clr_cause_t        clr_cause;

`ifdef LL_RSV_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;

  assign tmo_hit = valid_q & (cnt_q == '1);

  always_comb begin
    cnt_d = '0;
    if (valid_d && !take_ll) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Priority: flush > SC > LL > snoop kill > timeout > hold.
  always_comb begin
    clr_cause = ClrNone;
    take_ll   = 1'b0;
    if (flush) begin
      clr_cause = ClrFlush;
    end else if (sc_vld) begin
      clr_cause = ClrSc;
    end else if (ll_vld) begin
      take_ll = 1'b1;
    end else if (kill) begin
      clr_cause = ClrKill;
    end else if (tmo_hit) begin
      clr_cause = ClrTmo;
    end
    valid_d = take_ll | (valid_q & (clr_cause == ClrNone));
    addr_d  = take_ll ? ll_addr : addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid    = valid_q;
  assign rsv_addr = addr_q;

endmodule

// File: rtl/ll_reservation_unit.sv
// Multi-channel LL/SC reservation monitor: per-channel entries plus snoop-kill and SC arbitration.
// Define LL_RSV_TIMEOUT_EN to bound reservation lifetime with a TMO_W counter.
module ll_reservation_unit
  import ll_rsv_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned GRAN_LSB = 2,
  parameter int unsigned TMO_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ll_vld_i,
  input  logic [NUM_CH-1:0]        sc_vld_i,
  input  logic [NUM_CH-1:0]        st_vld_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  input  logic [NUM_CH-1:0]        flush_i,
  output logic [NUM_CH-1:0]        sc_ok_o,
  output logic [NUM_CH-1:0]        llbit_o
);

  logic [ADDR_W-1:0] acc_addr [NUM_CH];
  logic [ADDR_W-1:0] rsv_addr [NUM_CH];
  logic [NUM_CH-1:0] valid;
  logic [NUM_CH-1:0] sc_pre, store_kill, sc_cand, lost_arb, sc_ok, kill_now;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign acc_addr[c] = addr_i[c*ADDR_W +: ADDR_W];

    ll_rsv_entry #(
      .ADDR_W (ADDR_W),
      .TMO_W  (TMO_W)
    ) u_entry (
      .clk      (clk),
      .rst      (rst),
      .ll_vld   (ll_vld_i[c]),
      .sc_vld   (sc_vld_i[c]),
      .flush    (flush_i[c]),
      .kill     (kill_now[c]),
      .ll_addr  (acc_addr[c]),
      .valid    (valid[c]),
      .rsv_addr (rsv_addr[c])
    );
  end

  // Colliding SCs are resolved by arbitration rather than by mutual kill, so exactly one wins.
  always_comb begin
    sc_pre     = '0;
    store_kill = '0;
    lost_arb   = '0;
    kill_now   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sc_pre[c] = sc_vld_i[c] & valid[c] &
                  gran_match(MaxAddrW'(acc_addr[c]), MaxAddrW'(rsv_addr[c]), GRAN_LSB);
      for (int j = 0; j < NUM_CH; j++) begin
        if (j != c && st_vld_i[j] &&
            gran_match(MaxAddrW'(acc_addr[j]), MaxAddrW'(rsv_addr[c]), GRAN_LSB)) begin
          store_kill[c] = 1'b1;
        end
      end
    end
    sc_cand = sc_pre & ~store_kill;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < c; j++) begin
        if (sc_cand[j] &&
            gran_match(MaxAddrW'(acc_addr[j]), MaxAddrW'(acc_addr[c]), GRAN_LSB)) begin
          lost_arb[c] = 1'b1;
        end
      end
    end
    sc_ok = sc_cand & ~lost_arb;
    for (int c = 0; c < NUM_CH; c++) begin
      kill_now[c] = store_kill[c];
      for (int j = 0; j < NUM_CH; j++) begin
        if (j != c && sc_ok[j] &&
            gran_match(MaxAddrW'(acc_addr[j]), MaxAddrW'(rsv_addr[c]), GRAN_LSB)) begin
          kill_now[c] = 1'b1;
        end
      end
    end
  end

  assign sc_ok_o = sc_ok;
  assign llbit_o = valid;

endmodule

// File: tb/tb_ll_reservation_unit.sv
// Scoreboard bench for ll_reservation_unit: stimulus queues expectations, a negedge monitor checks.
module tb_ll_reservation_unit;

  logic        clk;
  logic        rst;
  logic [1:0]  ll_vld_i, sc_vld_i, st_vld_i, flush_i;
  logic [63:0] addr_i;
  logic [1:0]  sc_ok_o, llbit_o;

  ll_reservation_unit #(
    .NUM_CH   (2),
    .ADDR_W   (32),
    .GRAN_LSB (2),
    .TMO_W    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ll_vld_i (ll_vld_i),
    .sc_vld_i (sc_vld_i),
    .st_vld_i (st_vld_i),
    .addr_i   (addr_i),
    .flush_i  (flush_i),
    .sc_ok_o  (sc_ok_o),
    .llbit_o  (llbit_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at;
    bit         is_ll;
    logic [1:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      exp_t       e;
      logic [1:0] act;
      e   = q.pop_front();
      act = e.is_ll ? llbit_o : sc_ok_o;
      n_tests++;
      if (e.at != cyc || act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc, e.at);
      end
    end
  end

  task automatic ex(input bit is_ll, input logic [1:0] val, input string name);
    q.push_back('{cyc, is_ll, val, name});
  endtask

  task automatic step(input logic [1:0] ll, input logic [1:0] sc, input logic [1:0] st,
                      input logic [1:0] fl, input logic [31:0] a0, input logic [31:0] a1);
    ll_vld_i = ll;
    sc_vld_i = sc;
    st_vld_i = st;
    flush_i  = fl;
    addr_i   = {a1, a0};
    @(posedge clk);
    #1;
    ll_vld_i = '0;
    sc_vld_i = '0;
    st_vld_i = '0;
    flush_i  = '0;
    addr_i   = '0;
  endtask

  task automatic idle();
    step(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ll_vld_i = '0; sc_vld_i = '0; st_vld_i = '0; flush_i = '0; addr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++;
    if (sc_ok_o !== 2'b00 || llbit_o !== 2'b00) begin
      n_fail++;
      $display("FAIL direct_reset: sc_ok %b llbit %b", sc_ok_o, llbit_o);
    end
    ex(1, 2'b00, "reset_llbit");
    ex(0, 2'b00, "reset_scok");
    idle();

    // LL then SC on the same channel succeeds and consumes the reservation.
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0);
    n_tests++;
    if (llbit_o !== 2'b01) begin
      n_fail++;
      $display("FAIL direct_ll_bit: got %b expected 01", llbit_o);
    end
    ex(1, 2'b01, "ll_sets_bit");
    idle();
    ex(0, 2'b01, "sc_success");
    step(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0);
    n_tests++;
    if (llbit_o !== 2'b00) begin
      n_fail++;
      $display("FAIL direct_sc_consumes: got %b expected 00", llbit_o);
    end
    ex(1, 2'b00, "sc_consumes");

    // Foreign store inside the same word kills the reservation.
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'h1000, 32'h0);
    step(2'b00, 2'b00, 2'b10, 2'b00, 32'h0, 32'h1002);
    ex(1, 2'b00, "snoop_kill");
    ex(0, 2'b00, "sc_after_kill");
    step(2'b00, 2'b01, 2'b00, 2'b00, 32'h1000, 32'h0);

    // Two SCs to the same granule: lowest index wins, both reservations drop.
    step(2'b11, 2'b00, 2'b00, 2'b00, 32'h2000, 32'h2000);
    ex(1, 2'b11, "both_ll");
    ex(0, 2'b01, "sc_arbitration");
    step(2'b00, 2'b11, 2'b00, 2'b00, 32'h2000, 32'h2000);
    ex(1, 2'b00, "arb_both_cleared");

    // Flush with SC in the same cycle: SC sees old state, reservation cleared after.
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'h3000, 32'h0);
    ex(0, 2'b01, "flush_sc_old_state");
    step(2'b00, 2'b01, 2'b00, 2'b01, 32'h3000, 32'h0);
    ex(1, 2'b00, "flush_clears");
    step(2'b01, 2'b00, 2'b10, 2'b00, 32'h4000, 32'h4000);
    ex(1, 2'b01, "ll_beats_snoop");
    step(2'b00, 2'b00, 2'b10, 2'b00, 32'h0, 32'h4004);
    ex(1, 2'b01, "other_granule_store");
    step(2'b00, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0);
    ex(1, 2'b00, "flush_only");

    // Reset mid-operation discards the reservation.
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'h5000, 32'h0);
    ex(1, 2'b01, "pre_rst_bit");
    rst = 1'b1;
    idle();
    rst = 1'b0;
    ex(1, 2'b00, "rst_clears");
    ex(0, 2'b00, "sc_after_rst");
    step(2'b00, 2'b01, 2'b00, 2'b00, 32'h5000, 32'h0);

    // Own plain store keeps the channel's reservation.
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'h6000, 32'h0);
    step(2'b00, 2'b00, 2'b01, 2'b00, 32'h6000, 32'h0);
    ex(1, 2'b01, "own_store_keeps");
    step(2'b00, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0);

    // Successful SC on ch0 kills ch1's matching reservation.
    step(2'b11, 2'b00, 2'b00, 2'b00, 32'h7000, 32'h7000);
    ex(0, 2'b01, "sc_single");
    step(2'b00, 2'b01, 2'b00, 2'b00, 32'h7000, 32'h0);
    ex(1, 2'b00, "sc_kills_other");

    // Re-arming LL moves the reservation to the new address.
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'h8000, 32'h0);
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'h9000, 32'h0);
    ex(1, 2'b01, "rearm_bit");
    ex(0, 2'b00, "sc_old_addr_fails");
    step(2'b00, 2'b01, 2'b00, 2'b00, 32'h8000, 32'h0);
    ex(1, 2'b00, "failed_sc_clears");

    // Different granules: both SCs succeed.
    step(2'b11, 2'b00, 2'b00, 2'b00, 32'hA000, 32'hB000);
    ex(0, 2'b11, "sc_both_distinct");
    step(2'b00, 2'b11, 2'b00, 2'b00, 32'hA000, 32'hB000);
    ex(1, 2'b00, "distinct_cleared");

    // Lifetime bound.
    step(2'b01, 2'b00, 2'b00, 2'b00, 32'hC000, 32'h0);
`ifdef LL_RSV_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      ex(1, 2'b01, "tmo_hold");
      idle();
    end
    ex(1, 2'b00, "tmo_expire");
    idle();
`else
    repeat (100) idle();
    ex(1, 2'b01, "no_tmo_holds");
    step(2'b00, 2'b00, 2'b00, 2'b01, 32'h0, 32'h0);
    ex(1, 2'b00, "no_tmo_flush");
    idle();
`endif

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 5 && q.size() > 0; i++) idle();
    n_tests++;
    if (llbit_o !== 2'b00) begin
      n_fail++;
      $display("FAIL direct_final_clear: got %b expected 00", llbit_o);
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected %b", e.name, e.val);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
